sync_fifo: RTL and testbench

//  Single-clock synchronous FIFO buffering DATA_W-bit words between a producer (wr) and a consumer (rd).

---
 rtl/sync_fifo_if.sv | 42 ++++
 rtl/sync_fifo.sv | 89 ++++++++
 tb/tb_sync_fifo.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo; overflow/underflow exist only with FIFO_ERR_FLAGS_EN.
// master = the block driving rd/wr/data_in, slave = the FIFO itself.
interface sync_fifo_if #(
    parameter int DATA_W = 8
);
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic              overflow;
    logic              underflow;
`endif

    modport master (
        output rd,
        output wr,
        output data_in,
        input  data_out,
        input  full,
`ifdef FIFO_ERR_FLAGS_EN
        input  overflow,
        input  underflow,
`endif
        input  empty
    );

    modport slave (
        input  rd,
        input  wr,
        input  data_in,
        output data_out,
        output full,
`ifdef FIFO_ERR_FLAGS_EN
        output overflow,
        output underflow,
`endif
        output empty
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock DEPTH x DATA_W FIFO; FIFO_ERR_FLAGS_EN adds overflow/underflow pulses.
// Latency: data_out registered on the edge that accepts rd; a write is readable from the next edge.
// Backpressure: wr ignored while full, rd ignored while empty (no fall-through when empty).
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic       clock,
    input  logic       rst,
    sync_fifo_if.slave bus
);
    localparam int              ADDR_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_nxt;
    logic [DATA_W-1:0] dout_q;
    logic              full_q;
    logic              empty_q;
    logic              wr_ok;
    logic              rd_ok;

    // Each side is gated only by its own pre-edge flag.
    assign wr_ok = bus.wr && !full_q;
    assign rd_ok = bus.rd && !empty_q;

    always_comb begin
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            dout_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr   <= rptr + 1'b1;
                dout_q <= mem[rptr];
            end
            count   <= count_nxt;
            full_q  <= (count_nxt == FULL_CNT);
            empty_q <= (count_nxt == '0);
        end
    end

    assign bus.data_out = dout_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= bus.wr && full_q;
            unf_q <= bus.rd && empty_q;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_sync_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    always #5 clock = ~clock;

    sync_fifo_if #(.DATA_W(DATA_W)) bus ();

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    // Reference model: a plain queue of accepted words plus last value read.
    logic [DATA_W-1:0] q [$];
    logic [DATA_W-1:0] exp_dout;
    logic              exp_ovf;
    logic              exp_unf;
    int                checks;
    int                errors;

    task automatic cycle(input logic w, input logic r, input logic [DATA_W-1:0] d);
        bit rd_acc;
        bit wr_acc;
        bus.wr      = w;
        bus.rd      = r;
        bus.data_in = d;
        @(posedge clock);
        exp_ovf = w && (q.size() == DEPTH);
        exp_unf = r && (q.size() == 0);
        rd_acc  = r && (q.size() > 0);
        wr_acc  = w && (q.size() < DEPTH);
        if (rd_acc) exp_dout = q.pop_front();
        if (wr_acc) q.push_back(d);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: empty=%b full=%b dout=%h, want 1 0 00", bus.empty, bus.full, bus.data_out);
        end
`ifdef FIFO_ERR_FLAGS_EN
        checks++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_errflags: ovf=%b unf=%b, want 0 0", bus.overflow, bus.underflow);
        end
`endif
        model_reset();
        @(negedge clock) rst = 1'b0;
        @(posedge clock) #1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h11 + i));
            checks++;
            if (bus.empty !== 1'b0 || bus.full !== 1'b0) begin
                errors++;
                $display("FAIL basic_wr_flags[%0d]: empty=%b full=%b, want 0 0", i, bus.empty, bus.full);
            end
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            checks++;
            if (bus.data_out !== 8'(8'h11 + i) || bus.data_out !== exp_dout) begin
                errors++;
                $display("FAIL basic_rd[%0d]: got %h want %h", i, bus.data_out, 8'(8'h11 + i));
            end
        end
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_empty: got %b want 1", bus.empty);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h40 + i));
            checks++;
            if (bus.full !== (i == DEPTH - 1)) begin
                errors++;
                $display("FAIL full_fill[%0d]: full=%b want %b", i, bus.full, (i == DEPTH - 1));
            end
        end
        cycle(1'b1, 1'b0, 8'hFF);
        checks++;
        if (bus.full !== 1'b1 || bus.empty !== 1'b0 || q.size() != DEPTH) begin
            errors++;
            $display("FAIL full_extra_write: full=%b empty=%b, want 1 0", bus.full, bus.empty);
        end
`ifdef FIFO_ERR_FLAGS_EN
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_pulse: got %b want 1", bus.overflow);
        end
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: got %b want 0", bus.overflow);
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            checks++;
            if (bus.data_out !== 8'(8'h40 + i)) begin
                errors++;
                $display("FAIL full_drain[%0d]: got %h want %h", i, bus.data_out, 8'(8'h40 + i));
            end
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL full_drained_flags: empty=%b full=%b, want 1 0", bus.empty, bus.full);
        end
    endtask

    task automatic test_underflow();
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (bus.data_out !== 8'h4F || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow_hold: dout=%h empty=%b, want 4f 1", bus.data_out, bus.empty);
        end
`ifdef FIFO_ERR_FLAGS_EN
        checks++;
        if (bus.underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_pulse: got %b want 1", bus.underflow);
        end
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: got %b want 0", bus.underflow);
        end
`endif
        cycle(1'b1, 1'b0, 8'hA5);
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (bus.data_out !== 8'hA5 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow_ptrs: dout=%h empty=%b, want a5 1", bus.data_out, bus.empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] want;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 8'(8'h70 + i));
            want = (i < 8) ? 8'(8'h60 + i) : 8'(8'h70 + i - 8);
            checks++;
            if (bus.data_out !== want || bus.full !== 1'b0 || bus.empty !== 1'b0) begin
                errors++;
                $display("FAIL b2b[%0d]: dout=%h full=%b empty=%b, want %h 0 0", i, bus.data_out, bus.full, bus.empty, want);
            end
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            want = 8'(8'h7C + i);
            checks++;
            if (bus.data_out !== want || bus.empty !== (i == 7)) begin
                errors++;
                $display("FAIL b2b_drain[%0d]: dout=%h empty=%b, want %h %b", i, bus.data_out, bus.empty, want, (i == 7));
            end
        end
        cycle(1'b1, 1'b1, 8'hC3);
        checks++;
        if (bus.empty !== 1'b0 || bus.data_out !== 8'h83) begin
            errors++;
            $display("FAIL b2b_empty_rdwr: empty=%b dout=%h, want 0 83", bus.empty, bus.data_out);
        end
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (bus.data_out !== 8'hC3 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL b2b_empty_rd: dout=%h empty=%b, want c3 1", bus.data_out, bus.empty);
        end
    endtask

    task automatic test_random();
        logic w;
        logic r;
        int   thr;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst = 1'b1;
                #1;
                checks++;
                if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.data_out !== 8'h00) begin
                    errors++;
                    $display("FAIL rand_midreset: empty=%b full=%b dout=%h, want 1 0 00", bus.empty, bus.full, bus.data_out);
                end
                model_reset();
                @(negedge clock) rst = 1'b0;
                @(posedge clock) #1;
            end
            thr = ((i / 40) % 2 == 0) ? 70 : 30;
            w   = ($urandom_range(0, 99) < thr);
            r   = ($urandom_range(0, 99) < (100 - thr));
            cycle(w, r, 8'($urandom));
            checks++;
            if (bus.data_out !== exp_dout || bus.full !== (q.size() == DEPTH) || bus.empty !== (q.size() == 0)) begin
                errors++;
                $display("FAIL rand[%0d]: dout=%h full=%b empty=%b, want %h %b %b", i, bus.data_out, bus.full, bus.empty, exp_dout, (q.size() == DEPTH), (q.size() == 0));
            end
`ifdef FIFO_ERR_FLAGS_EN
            checks++;
            if (bus.overflow !== exp_ovf || bus.underflow !== exp_unf) begin
                errors++;
                $display("FAIL rand_err[%0d]: ovf=%b unf=%b, want %b %b", i, bus.overflow, bus.underflow, exp_ovf, exp_unf);
            end
`endif
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.data_in = '0;
        model_reset();
        test_reset();
        test_basic();
        test_full();
        test_underflow();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
